// File: rtl/rv32_decode_pkg.sv
// Shared decode definitions: opcodes, funct3 codes, unit opcode encodings and the control bundle.
// The M extension codes are used only when RV32_DECODE_M_EXT_EN is defined.
package rv32_decode_pkg;

  localparam int DEC_XLEN       = 32;
  localparam int DEC_REG_ADDR_W = 5;
  localparam int DEC_CSR_ADDR_W = 12;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_PRIV   = 3'b000;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam int DATA_ORIGIN_WIDTH = 2;
  localparam logic [1:0] ORIGIN_REGISTER = 2'd0;
  localparam logic [1:0] ORIGIN_RS1_IMM  = 2'd1;
  localparam logic [1:0] ORIGIN_PC_IMM   = 2'd2;

  localparam int DATA_TARGET_WIDTH = 2;
  localparam logic [1:0] TARGET_ALU = 2'd0;
  localparam logic [1:0] TARGET_MEM = 2'd1;
  localparam logic [1:0] TARGET_PC  = 2'd2;
  localparam logic [1:0] TARGET_CSR = 2'd3;

  localparam int ALU_OPCODE_WIDTH = 5;
  localparam logic [4:0] ALU_OPCODE_ADD    = 5'd0;
  localparam logic [4:0] ALU_OPCODE_SUB    = 5'd1;
  localparam logic [4:0] ALU_OPCODE_SLL    = 5'd2;
  localparam logic [4:0] ALU_OPCODE_SLT    = 5'd3;
  localparam logic [4:0] ALU_OPCODE_SLTU   = 5'd4;
  localparam logic [4:0] ALU_OPCODE_XOR    = 5'd5;
  localparam logic [4:0] ALU_OPCODE_SRL    = 5'd6;
  localparam logic [4:0] ALU_OPCODE_SRA    = 5'd7;
  localparam logic [4:0] ALU_OPCODE_OR     = 5'd8;
  localparam logic [4:0] ALU_OPCODE_AND    = 5'd9;
  // M extension codes are contiguous in funct3 order so decode is ALU_OPCODE_MUL + funct3.
  localparam logic [4:0] ALU_OPCODE_MUL    = 5'd10;
  localparam logic [4:0] ALU_OPCODE_MULH   = 5'd11;
  localparam logic [4:0] ALU_OPCODE_MULHSU = 5'd12;
  localparam logic [4:0] ALU_OPCODE_MULHU  = 5'd13;
  localparam logic [4:0] ALU_OPCODE_DIV    = 5'd14;
  localparam logic [4:0] ALU_OPCODE_DIVU   = 5'd15;
  localparam logic [4:0] ALU_OPCODE_REM    = 5'd16;
  localparam logic [4:0] ALU_OPCODE_REMU   = 5'd17;

  localparam int LSU_OPCODE_WIDTH = 4;
  localparam logic [3:0] LSU_OPCODE_NONE = 4'd0;
  localparam logic [3:0] LSU_OPCODE_LB   = 4'd1;
  localparam logic [3:0] LSU_OPCODE_LH   = 4'd2;
  localparam logic [3:0] LSU_OPCODE_LW   = 4'd3;
  localparam logic [3:0] LSU_OPCODE_LBU  = 4'd4;
  localparam logic [3:0] LSU_OPCODE_LHU  = 4'd5;
  localparam logic [3:0] LSU_OPCODE_SB   = 4'd6;
  localparam logic [3:0] LSU_OPCODE_SH   = 4'd7;
  localparam logic [3:0] LSU_OPCODE_SW   = 4'd8;

  localparam int BR_OPCODE_WIDTH = 3;
  localparam logic [2:0] BR_OPCODE_NONE = 3'd0;
  localparam logic [2:0] BR_OPCODE_BEQ  = 3'd1;
  localparam logic [2:0] BR_OPCODE_BNE  = 3'd2;
  localparam logic [2:0] BR_OPCODE_BLT  = 3'd3;
  localparam logic [2:0] BR_OPCODE_BGE  = 3'd4;
  localparam logic [2:0] BR_OPCODE_BLTU = 3'd5;
  localparam logic [2:0] BR_OPCODE_BGEU = 3'd6;
  localparam logic [2:0] BR_OPCODE_JUMP = 3'd7;

  localparam int CSR_OPCODE_WIDTH = 3;
  localparam logic [2:0] CSR_OPCODE_NONE   = 3'd0;
  localparam logic [2:0] CSR_OPCODE_CSRRW  = 3'd1;
  localparam logic [2:0] CSR_OPCODE_CSRRS  = 3'd2;
  localparam logic [2:0] CSR_OPCODE_CSRRC  = 3'd3;
  localparam logic [2:0] CSR_OPCODE_CSRRWI = 3'd4;
  localparam logic [2:0] CSR_OPCODE_CSRRSI = 3'd5;
  localparam logic [2:0] CSR_OPCODE_CSRRCI = 3'd6;

  typedef struct packed {
    logic [DEC_XLEN-1:0]       pc;
    logic [1:0]                data_origin;
    logic [1:0]                data_target;
    logic [DEC_XLEN-1:0]       imm;
    logic [DEC_REG_ADDR_W-1:0] rs1_addr;
    logic [DEC_REG_ADDR_W-1:0] rs2_addr;
    logic [DEC_REG_ADDR_W-1:0] rd_addr;
    logic [4:0]                alu_opcode;
    logic [3:0]                lsu_opcode;
    logic [2:0]                br_opcode;
    logic [2:0]                csr_opcode;
    logic [DEC_CSR_ADDR_W-1:0] csr_addr;
    logic                      csr_we;
    logic                      csr_re;
    logic                      reg_w;
    logic                      mem_w;
    logic                      is_branch;
    logic                      is_condition;
  } dec_bundle_t;

  // Idle bundle: every field zero apart from the two opcodes with non-trivial idle meaning.
  function automatic dec_bundle_t idle_bundle();
    dec_bundle_t b;
    b            = '0;
    b.lsu_opcode = LSU_OPCODE_NONE;
    b.alu_opcode = ALU_OPCODE_ADD;
    return b;
  endfunction

endpackage

// File: rtl/rv32_decode_comb.sv
// Pure combinational RV32I(+M) instruction decoder: instruction word and PC in, control bundle and illegal flag out.
// Multiply/divide encodings are decoded only when RV32_DECODE_M_EXT_EN is defined.
module rv32_decode_comb
  import rv32_decode_pkg::*;
(
  input  logic [31:0]         inst_i,
  input  logic [DEC_XLEN-1:0] pc_i,
  output dec_bundle_t         bundle_o,
  output logic                illegal_o
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [DEC_XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_z;

  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign f7     = inst_i[31:25];

  assign imm_i = {{(DEC_XLEN-12){inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{(DEC_XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{(DEC_XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_j = {{(DEC_XLEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_u = {inst_i[31:12], 12'b0};
  assign imm_z = {{(DEC_XLEN-5){1'b0}}, inst_i[19:15]};

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned and infers a latch.
    bundle_o    = idle_bundle();
    bundle_o.pc = pc_i;
    illegal_o   = 1'b0;

    case (opcode)
      OPC_LUI: begin
        bundle_o.rd_addr     = inst_i[11:7];
        bundle_o.imm         = imm_u;
        bundle_o.data_origin = ORIGIN_RS1_IMM;
        bundle_o.reg_w       = 1'b1;
      end
      OPC_AUIPC: begin
        bundle_o.rd_addr     = inst_i[11:7];
        bundle_o.imm         = imm_u;
        bundle_o.data_origin = ORIGIN_PC_IMM;
        bundle_o.reg_w       = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        bundle_o.rd_addr     = inst_i[11:7];
        bundle_o.data_target = TARGET_PC;
        bundle_o.br_opcode   = BR_OPCODE_JUMP;
        bundle_o.is_branch   = 1'b1;
        bundle_o.reg_w       = 1'b1;
        if (opcode == OPC_JAL) begin
          bundle_o.imm         = imm_j;
          bundle_o.data_origin = ORIGIN_PC_IMM;
        end else begin
          bundle_o.rs1_addr    = inst_i[19:15];
          bundle_o.imm         = imm_i;
          bundle_o.data_origin = ORIGIN_RS1_IMM;
          illegal_o            = (f3 != 3'b000);
        end
      end
      OPC_BRANCH: begin
        bundle_o.rs1_addr     = inst_i[19:15];
        bundle_o.rs2_addr     = inst_i[24:20];
        bundle_o.imm          = imm_b;
        bundle_o.is_branch    = 1'b1;
        bundle_o.is_condition = 1'b1;
        case (f3)
          3'b000:  begin bundle_o.br_opcode = BR_OPCODE_BEQ;  bundle_o.alu_opcode = ALU_OPCODE_SUB;  end
          3'b001:  begin bundle_o.br_opcode = BR_OPCODE_BNE;  bundle_o.alu_opcode = ALU_OPCODE_SUB;  end
          3'b100:  begin bundle_o.br_opcode = BR_OPCODE_BLT;  bundle_o.alu_opcode = ALU_OPCODE_SLT;  end
          3'b101:  begin bundle_o.br_opcode = BR_OPCODE_BGE;  bundle_o.alu_opcode = ALU_OPCODE_SLT;  end
          3'b110:  begin bundle_o.br_opcode = BR_OPCODE_BLTU; bundle_o.alu_opcode = ALU_OPCODE_SLTU; end
          3'b111:  begin bundle_o.br_opcode = BR_OPCODE_BGEU; bundle_o.alu_opcode = ALU_OPCODE_SLTU; end
          default: illegal_o = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        bundle_o.rd_addr     = inst_i[11:7];
        bundle_o.rs1_addr    = inst_i[19:15];
        bundle_o.imm         = imm_i;
        bundle_o.data_origin = ORIGIN_RS1_IMM;
        bundle_o.data_target = TARGET_MEM;
        bundle_o.reg_w       = 1'b1;
        case (f3)
          3'b000:  bundle_o.lsu_opcode = LSU_OPCODE_LB;
          3'b001:  bundle_o.lsu_opcode = LSU_OPCODE_LH;
          3'b010:  bundle_o.lsu_opcode = LSU_OPCODE_LW;
          3'b100:  bundle_o.lsu_opcode = LSU_OPCODE_LBU;
          3'b101:  bundle_o.lsu_opcode = LSU_OPCODE_LHU;
          default: illegal_o = 1'b1;
        endcase
      end
      OPC_STORE: begin
        bundle_o.rs1_addr    = inst_i[19:15];
        bundle_o.rs2_addr    = inst_i[24:20];
        bundle_o.imm         = imm_s;
        bundle_o.data_origin = ORIGIN_RS1_IMM;
        bundle_o.mem_w       = 1'b1;
        case (f3)
          3'b000:  bundle_o.lsu_opcode = LSU_OPCODE_SB;
          3'b001:  bundle_o.lsu_opcode = LSU_OPCODE_SH;
          3'b010:  bundle_o.lsu_opcode = LSU_OPCODE_SW;
          default: illegal_o = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        bundle_o.rd_addr     = inst_i[11:7];
        bundle_o.rs1_addr    = inst_i[19:15];
        bundle_o.imm         = imm_i;
        bundle_o.data_origin = ORIGIN_RS1_IMM;
        bundle_o.reg_w       = 1'b1;
        case (f3)
          3'b000: bundle_o.alu_opcode = ALU_OPCODE_ADD;
          3'b010: bundle_o.alu_opcode = ALU_OPCODE_SLT;
          3'b011: bundle_o.alu_opcode = ALU_OPCODE_SLTU;
          3'b100: bundle_o.alu_opcode = ALU_OPCODE_XOR;
          3'b110: bundle_o.alu_opcode = ALU_OPCODE_OR;
          3'b111: bundle_o.alu_opcode = ALU_OPCODE_AND;
          3'b001: begin
            bundle_o.alu_opcode = ALU_OPCODE_SLL;
            illegal_o           = (f7 != 7'b0000000);
          end
          default: begin
            if (f7 == 7'b0000000)      bundle_o.alu_opcode = ALU_OPCODE_SRL;
            else if (f7 == 7'b0100000) bundle_o.alu_opcode = ALU_OPCODE_SRA;
            else                       illegal_o = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        bundle_o.rd_addr     = inst_i[11:7];
        bundle_o.rs1_addr    = inst_i[19:15];
        bundle_o.rs2_addr    = inst_i[24:20];
        bundle_o.data_origin = ORIGIN_REGISTER;
        bundle_o.reg_w       = 1'b1;
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000:  bundle_o.alu_opcode = ALU_OPCODE_ADD;
              3'b001:  bundle_o.alu_opcode = ALU_OPCODE_SLL;
              3'b010:  bundle_o.alu_opcode = ALU_OPCODE_SLT;
              3'b011:  bundle_o.alu_opcode = ALU_OPCODE_SLTU;
              3'b100:  bundle_o.alu_opcode = ALU_OPCODE_XOR;
              3'b101:  bundle_o.alu_opcode = ALU_OPCODE_SRL;
              3'b110:  bundle_o.alu_opcode = ALU_OPCODE_OR;
              default: bundle_o.alu_opcode = ALU_OPCODE_AND;
            endcase
          end
          7'b0100000: begin
            if (f3 == 3'b000)      bundle_o.alu_opcode = ALU_OPCODE_SUB;
            else if (f3 == 3'b101) bundle_o.alu_opcode = ALU_OPCODE_SRA;
            else                   illegal_o = 1'b1;
          end
`ifdef RV32_DECODE_M_EXT_EN
          7'b0000001: bundle_o.alu_opcode = ALU_OPCODE_MUL + {2'b00, f3};
`endif
          default: illegal_o = 1'b1;
        endcase
      end
      OPC_FENCE: ;
      OPC_SYSTEM: begin
        if (f3 == F3_PRIV) begin
          // ECALL/EBREAK and friends carry no writes; the trap unit interprets them downstream.
        end else if (f3 == 3'b100) begin
          illegal_o = 1'b1;
        end else begin
          bundle_o.rd_addr     = inst_i[11:7];
          bundle_o.csr_addr    = inst_i[31:20];
          bundle_o.data_target = TARGET_CSR;
          bundle_o.reg_w       = 1'b1;
          bundle_o.csr_re      = 1'b1;
          bundle_o.csr_we      = (inst_i[19:15] != 5'd0);
          if (f3[2]) begin
            bundle_o.imm         = imm_z;
            bundle_o.data_origin = ORIGIN_RS1_IMM;
          end else begin
            bundle_o.rs1_addr    = inst_i[19:15];
          end
          case (f3)
            F3_CSRRW: begin
              bundle_o.csr_opcode = CSR_OPCODE_CSRRW;
              bundle_o.csr_we     = 1'b1;
              bundle_o.csr_re     = (inst_i[11:7] != 5'd0);
            end
            F3_CSRRS:  bundle_o.csr_opcode = CSR_OPCODE_CSRRS;
            F3_CSRRC:  bundle_o.csr_opcode = CSR_OPCODE_CSRRC;
            F3_CSRRWI: begin
              bundle_o.csr_opcode = CSR_OPCODE_CSRRWI;
              bundle_o.csr_we     = 1'b1;
            end
            F3_CSRRSI: bundle_o.csr_opcode = CSR_OPCODE_CSRRSI;
            default:   bundle_o.csr_opcode = CSR_OPCODE_CSRRCI;
          endcase
        end
      end
      default: illegal_o = 1'b1;
    endcase

    if (inst_i[1:0] != 2'b11 || inst_i == 32'h0000_0000 || inst_i == 32'hFFFF_FFFF)
      illegal_o = 1'b1;

    // An illegal instruction must never commit architectural side effects.
    if (illegal_o) begin
      bundle_o.reg_w     = 1'b0;
      bundle_o.mem_w     = 1'b0;
      bundle_o.csr_we    = 1'b0;
      bundle_o.is_branch = 1'b0;
    end
  end

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32I decode pipeline stage: rv32_decode_comb behind a valid/ready output register (OUT_REG=1) or a pass-through (OUT_REG=0).
// Define RV32_DECODE_M_EXT_EN to decode the M extension.
module rv32_decode_stage
  import rv32_decode_pkg::*;
#(
  parameter int XLEN       = DEC_XLEN,
  parameter int REG_ADDR_W = DEC_REG_ADDR_W,
  parameter int CSR_ADDR_W = DEC_CSR_ADDR_W,
  parameter bit OUT_REG    = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         inst_valid_i,
  output logic                         inst_ready_o,
  input  logic [31:0]                  inst_i,
  input  logic [XLEN-1:0]              pc_i,
  output logic                         dec_valid_o,
  input  logic                         dec_ready_i,
  output logic [XLEN-1:0]              pc_o,
  output logic [DATA_ORIGIN_WIDTH-1:0] data_origin_o,
  output logic [DATA_TARGET_WIDTH-1:0] data_target_o,
  output logic [XLEN-1:0]              imm_o,
  output logic [REG_ADDR_W-1:0]        rs1_addr_o,
  output logic [REG_ADDR_W-1:0]        rs2_addr_o,
  output logic [REG_ADDR_W-1:0]        rd_addr_o,
  output logic [ALU_OPCODE_WIDTH-1:0]  alu_opcode_o,
  output logic [LSU_OPCODE_WIDTH-1:0]  lsu_opcode_o,
  output logic [BR_OPCODE_WIDTH-1:0]   br_opcode_o,
  output logic [CSR_OPCODE_WIDTH-1:0]  csr_opcode_o,
  output logic [CSR_ADDR_W-1:0]        csr_addr_o,
  output logic                         csr_we_o,
  output logic                         csr_re_o,
  output logic                         reg_w_o,
  output logic                         mem_w_o,
  output logic                         is_branch_o,
  output logic                         is_condition_o,
  output logic                         illegal_o
);

  dec_bundle_t bundle_d, bundle_out;
  logic        illegal_d, illegal_out;

  rv32_decode_comb u_decode_comb (
    .inst_i    (inst_i),
    .pc_i      (pc_i),
    .bundle_o  (bundle_d),
    .illegal_o (illegal_d)
  );

  if (OUT_REG) begin : g_out_reg
    dec_bundle_t bundle_q;
    logic        illegal_q;
    logic        valid_q;
    logic        accept;

    assign inst_ready_o = !valid_q || dec_ready_i;
    assign accept       = inst_valid_i && inst_ready_o;

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q   <= 1'b0;
        bundle_q  <= idle_bundle();
        illegal_q <= 1'b0;
      end else begin
        if (flush_i)          valid_q <= 1'b0;
        else if (accept)      valid_q <= 1'b1;
        else if (dec_ready_i) valid_q <= 1'b0;

        // Flush drops the incoming instruction, so the held bundle is left untouched.
        if (accept && !flush_i) begin
          bundle_q  <= bundle_d;
          illegal_q <= illegal_d;
        end
      end
    end

    assign dec_valid_o = valid_q;
    assign bundle_out  = bundle_q;
    assign illegal_out = illegal_q;
  end else begin : g_pass
    assign inst_ready_o = dec_ready_i;
    assign dec_valid_o  = inst_valid_i && !flush_i;
    assign bundle_out   = bundle_d;
    assign illegal_out  = illegal_d;
  end

  assign pc_o           = bundle_out.pc;
  assign data_origin_o  = bundle_out.data_origin;
  assign data_target_o  = bundle_out.data_target;
  assign imm_o          = bundle_out.imm;
  assign rs1_addr_o     = bundle_out.rs1_addr;
  assign rs2_addr_o     = bundle_out.rs2_addr;
  assign rd_addr_o      = bundle_out.rd_addr;
  assign alu_opcode_o   = bundle_out.alu_opcode;
  assign lsu_opcode_o   = bundle_out.lsu_opcode;
  assign br_opcode_o    = bundle_out.br_opcode;
  assign csr_opcode_o   = bundle_out.csr_opcode;
  assign csr_addr_o     = bundle_out.csr_addr;
  assign csr_we_o       = bundle_out.csr_we;
  assign csr_re_o       = bundle_out.csr_re;
  assign reg_w_o        = bundle_out.reg_w;
  assign mem_w_o        = bundle_out.mem_w;
  assign is_branch_o    = bundle_out.is_branch;
  assign is_condition_o = bundle_out.is_condition;
  assign illegal_o      = illegal_out;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Directed testbench for rv32_decode_stage (OUT_REG=1): reset, streaming, backpressure, flush, illegal, CSR and M-extension decode.
// Expectations for mul follow RV32_DECODE_M_EXT_EN.
module tb_rv32_decode_stage;
  import rv32_decode_pkg::*;

  logic        clk, rst_n, flush_i, inst_valid_i, inst_ready_o, dec_valid_o, dec_ready_i;
  logic [31:0] inst_i, pc_i, pc_o, imm_o;
  logic [1:0]  data_origin_o, data_target_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o, alu_opcode_o;
  logic [3:0]  lsu_opcode_o;
  logic [2:0]  br_opcode_o, csr_opcode_o;
  logic [11:0] csr_addr_o;
  logic        csr_we_o, csr_re_o, reg_w_o, mem_w_o, is_branch_o, is_condition_o, illegal_o;

  int checks = 0;
  int errors = 0;

  rv32_decode_stage #(.XLEN(32), .REG_ADDR_W(5), .CSR_ADDR_W(12), .OUT_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .inst_i(inst_i), .pc_i(pc_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .pc_o(pc_o), .data_origin_o(data_origin_o), .data_target_o(data_target_o),
    .imm_o(imm_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
    .alu_opcode_o(alu_opcode_o), .lsu_opcode_o(lsu_opcode_o), .br_opcode_o(br_opcode_o),
    .csr_opcode_o(csr_opcode_o), .csr_addr_o(csr_addr_o),
    .csr_we_o(csr_we_o), .csr_re_o(csr_re_o), .reg_w_o(reg_w_o), .mem_w_o(mem_w_o),
    .is_branch_o(is_branch_o), .is_condition_o(is_condition_o), .illegal_o(illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0; inst_valid_i = 1'b0; dec_ready_i = 1'b0;
    inst_i = 32'h0; pc_i = 32'h0;
    #3;
    checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", dec_valid_o); end
    checks++; if (lsu_opcode_o !== LSU_OPCODE_NONE) begin errors++; $display("FAIL reset_lsu got %0h exp %0h", lsu_opcode_o, LSU_OPCODE_NONE); end
    checks++; if (alu_opcode_o !== ALU_OPCODE_ADD) begin errors++; $display("FAIL reset_alu got %0h exp %0h", alu_opcode_o, ALU_OPCODE_ADD); end
    checks++; if (imm_o !== 32'h0 || reg_w_o !== 1'b0 || pc_o !== 32'h0) begin errors++; $display("FAIL reset_fields imm %h reg_w %0h pc %h exp 0", imm_o, reg_w_o, pc_o); end
    checks++; if (inst_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0h exp 1", inst_ready_o); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    dec_ready_i = 1'b1; inst_valid_i = 1'b1;
    inst_i = 32'h0050_0093; pc_i = 32'h0000_0100;      // addi x1,x0,5
    tick();
    checks++; if (dec_valid_o !== 1'b1) begin errors++; $display("FAIL addi_valid got %0h exp 1", dec_valid_o); end
    checks++; if (alu_opcode_o !== ALU_OPCODE_ADD || imm_o !== 32'd5 || rd_addr_o !== 5'd1) begin
      errors++; $display("FAIL addi_bundle alu %0h imm %h rd %0d exp alu %0h imm 5 rd 1", alu_opcode_o, imm_o, rd_addr_o, ALU_OPCODE_ADD); end
    checks++; if (reg_w_o !== 1'b1 || pc_o !== 32'h100 || data_origin_o !== ORIGIN_RS1_IMM || illegal_o !== 1'b0) begin
      errors++; $display("FAIL addi_ctrl reg_w %0h pc %h origin %0h illegal %0h", reg_w_o, pc_o, data_origin_o, illegal_o); end
    inst_i = 32'hFE20_8EE3; pc_i = 32'h0000_0104;      // beq x1,x2,-4
    tick();
    checks++; if (is_condition_o !== 1'b1 || is_branch_o !== 1'b1 || br_opcode_o !== BR_OPCODE_BEQ) begin
      errors++; $display("FAIL beq_branch cond %0h br %0h brop %0h exp 1 1 %0h", is_condition_o, is_branch_o, br_opcode_o, BR_OPCODE_BEQ); end
    checks++; if (alu_opcode_o !== ALU_OPCODE_SUB || imm_o !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL beq_alu_imm alu %0h imm %h exp %0h fffffffc", alu_opcode_o, imm_o, ALU_OPCODE_SUB); end
    checks++; if (rs1_addr_o !== 5'd1 || rs2_addr_o !== 5'd2 || reg_w_o !== 1'b0 || pc_o !== 32'h104) begin
      errors++; $display("FAIL beq_regs rs1 %0d rs2 %0d reg_w %0h pc %h exp 1 2 0 104", rs1_addr_o, rs2_addr_o, reg_w_o, pc_o); end
    inst_valid_i = 1'b0;
    tick();
    checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL stream_drain got %0h exp 0", dec_valid_o); end
  endtask

  task automatic test_back_to_back_backpressure();
    dec_ready_i = 1'b0; inst_valid_i = 1'b1;
    inst_i = 32'h0011_2223; pc_i = 32'h0000_0200;      // sw x1,4(x2)
    tick();
    inst_i = 32'h0050_0093; pc_i = 32'h0000_0204;      // next instruction waits at the input
    for (int i = 0; i < 3; i++) begin
      checks++; if (dec_valid_o !== 1'b1 || inst_ready_o !== 1'b0) begin
        errors++; $display("FAIL hold_hs[%0d] valid %0h ready %0h exp 1 0", i, dec_valid_o, inst_ready_o); end
      checks++; if (mem_w_o !== 1'b1 || imm_o !== 32'd4 || lsu_opcode_o !== LSU_OPCODE_SW || pc_o !== 32'h200) begin
        errors++; $display("FAIL hold_bundle[%0d] mem_w %0h imm %h lsu %0h pc %h exp 1 4 %0h 200", i, mem_w_o, imm_o, lsu_opcode_o, pc_o, LSU_OPCODE_SW); end
      tick();
    end
    dec_ready_i = 1'b1;
    #1;
    checks++; if (inst_ready_o !== 1'b1) begin errors++; $display("FAIL release_ready got %0h exp 1", inst_ready_o); end
    tick();
    checks++; if (dec_valid_o !== 1'b1 || pc_o !== 32'h204 || imm_o !== 32'd5 || lsu_opcode_o !== LSU_OPCODE_NONE || mem_w_o !== 1'b0) begin
      errors++; $display("FAIL release_next valid %0h pc %h imm %h lsu %0h mem_w %0h exp 1 204 5 0 0", dec_valid_o, pc_o, imm_o, lsu_opcode_o, mem_w_o); end
    inst_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    dec_ready_i = 1'b1; inst_valid_i = 1'b1; flush_i = 1'b1;
    inst_i = 32'h0041_2083; pc_i = 32'h0000_0300;      // lw x1,4(x2)
    #1;
    checks++; if (inst_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready got %0h exp 1", inst_ready_o); end
    tick();
    checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %0h exp 0", dec_valid_o); end
    checks++; if (lsu_opcode_o !== LSU_OPCODE_NONE || pc_o === 32'h300) begin
      errors++; $display("FAIL flush_dropped lsu %0h pc %h exp lsu 0 and old pc", lsu_opcode_o, pc_o); end
    flush_i = 1'b0; inst_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    logic [31:0] vec [7];
    logic        exp_ill [7];
    vec[0] = 32'h0000_0000; exp_ill[0] = 1'b1;  // all zero
    vec[1] = 32'h2000_5093; exp_ill[1] = 1'b1;  // shift-right with bad func7
    vec[2] = 32'h0000_300B; exp_ill[2] = 1'b1;  // unknown opcode
    vec[3] = 32'hFFFF_FFFF; exp_ill[3] = 1'b1;  // all ones
    vec[4] = 32'h0050_0091; exp_ill[4] = 1'b1;  // inst[1:0] = 01
    vec[5] = 32'h0041_3083; exp_ill[5] = 1'b1;  // load funct3 011
    vec[6] = 32'h4000_5093; exp_ill[6] = 1'b0;  // srai x1,x0,0 is legal
    dec_ready_i = 1'b1; inst_valid_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      inst_i = vec[i]; pc_i = 32'h400 + 32'(i * 4);
      tick();
      checks++; if (dec_valid_o !== 1'b1 || illegal_o !== exp_ill[i]) begin
        errors++; $display("FAIL illegal[%0d] inst %h valid %0h illegal %0h exp 1 %0h", i, vec[i], dec_valid_o, illegal_o, exp_ill[i]); end
      checks++; if (reg_w_o !== !exp_ill[i] || mem_w_o !== 1'b0) begin
        errors++; $display("FAIL illegal_w[%0d] inst %h reg_w %0h mem_w %0h exp %0h 0", i, vec[i], reg_w_o, mem_w_o, !exp_ill[i]); end
    end
    checks++; if (alu_opcode_o !== ALU_OPCODE_SRA) begin errors++; $display("FAIL srai_alu got %0h exp %0h", alu_opcode_o, ALU_OPCODE_SRA); end
    inst_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_csr();
    dec_ready_i = 1'b1; inst_valid_i = 1'b1;
    inst_i = 32'h3000_22F3; pc_i = 32'h500;            // csrrs x5,mstatus,x0
    tick();
    checks++; if (csr_re_o !== 1'b1 || csr_we_o !== 1'b0 || csr_opcode_o !== CSR_OPCODE_CSRRS) begin
      errors++; $display("FAIL csrrs_rw re %0h we %0h op %0h exp 1 0 %0h", csr_re_o, csr_we_o, csr_opcode_o, CSR_OPCODE_CSRRS); end
    checks++; if (csr_addr_o !== 12'h300 || rd_addr_o !== 5'd5 || reg_w_o !== 1'b1 || illegal_o !== 1'b0) begin
      errors++; $display("FAIL csrrs_fields addr %h rd %0d reg_w %0h illegal %0h exp 300 5 1 0", csr_addr_o, rd_addr_o, reg_w_o, illegal_o); end
    inst_i = 32'h3000_9073; pc_i = 32'h504;            // csrrw x0,mstatus,x1
    tick();
    checks++; if (csr_re_o !== 1'b0 || csr_we_o !== 1'b1 || csr_opcode_o !== CSR_OPCODE_CSRRW || rs1_addr_o !== 5'd1) begin
      errors++; $display("FAIL csrrw_x0 re %0h we %0h op %0h rs1 %0d exp 0 1 %0h 1", csr_re_o, csr_we_o, csr_opcode_o, rs1_addr_o, CSR_OPCODE_CSRRW); end
    inst_i = 32'h3002_D1F3; pc_i = 32'h508;            // csrrwi x3,mstatus,5
    tick();
    checks++; if (imm_o !== 32'd5 || csr_we_o !== 1'b1 || csr_re_o !== 1'b1 || csr_opcode_o !== CSR_OPCODE_CSRRWI || rs1_addr_o !== 5'd0) begin
      errors++; $display("FAIL csrrwi imm %h we %0h re %0h op %0h rs1 %0d exp 5 1 1 %0h 0", imm_o, csr_we_o, csr_re_o, csr_opcode_o, rs1_addr_o, CSR_OPCODE_CSRRWI); end
    inst_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_m_ext();
    dec_ready_i = 1'b1; inst_valid_i = 1'b1;
    inst_i = 32'h0220_80B3; pc_i = 32'h600;            // mul x1,x1,x2
    tick();
`ifdef RV32_DECODE_M_EXT_EN
    checks++; if (illegal_o !== 1'b0 || alu_opcode_o !== ALU_OPCODE_MUL || reg_w_o !== 1'b1 || data_origin_o !== ORIGIN_REGISTER) begin
      errors++; $display("FAIL mul_decode illegal %0h alu %0h reg_w %0h origin %0h exp 0 %0h 1 0", illegal_o, alu_opcode_o, reg_w_o, data_origin_o, ALU_OPCODE_MUL); end
`else
    checks++; if (illegal_o !== 1'b1 || reg_w_o !== 1'b0) begin
      errors++; $display("FAIL mul_illegal illegal %0h reg_w %0h exp 1 0", illegal_o, reg_w_o); end
`endif
    inst_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_midstream();
    dec_ready_i = 1'b0; inst_valid_i = 1'b1;
    inst_i = 32'h0041_2083; pc_i = 32'h700;            // lw x1,4(x2)
    tick();
    checks++; if (dec_valid_o !== 1'b1 || lsu_opcode_o !== LSU_OPCODE_LW || imm_o !== 32'd4) begin
      errors++; $display("FAIL lw_loaded valid %0h lsu %0h imm %h exp 1 %0h 4", dec_valid_o, lsu_opcode_o, imm_o, LSU_OPCODE_LW); end
    rst_n = 1'b0;
    #1;
    checks++; if (dec_valid_o !== 1'b0 || lsu_opcode_o !== LSU_OPCODE_NONE || imm_o !== 32'h0 || reg_w_o !== 1'b0) begin
      errors++; $display("FAIL async_reset valid %0h lsu %0h imm %h reg_w %0h exp 0 0 0 0", dec_valid_o, lsu_opcode_o, imm_o, reg_w_o); end
    inst_valid_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_to_back_backpressure();
    test_flush();
    test_illegal();
    test_csr();
    test_m_ext();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
